position_stepper: RTL and testbench
===================================

// Module: position_stepper
// PURPOSE
//   Consumes the 8-bit two's-complement step produced by the sign extender and applies it to a
//   bounded position register at a programmable tick rate.
//   Typical steps: -1 (8'hFF), 0, +1 or -2 (8'hFE).
//   Output feeds object placement / display logic; saturates at MIN_POS/MAX_POS, flags edges.
// PARAMETERS
//   POS_W     8    width of position register (unsigned)
//   MIN_POS   0    lowest legal position (inclusive)
//   MAX_POS   159  highest legal position (inclusive); MIN_POS <= RST_POS <= MAX_POS < 2**POS_W
//   RST_POS   80   position loaded on reset
//   TICK_DIV  4    clk cycles per move tick while running (>=1)
// PORTS
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous reset, active-high
//   en        in   1      run enable; 0 freezes position and prescaler
//   step      in   8      signed step from sign extender, sampled on tick cycle only
//   load      in   1      synchronous load request
//   load_val  in   POS_W  value for load (clamped to [MIN_POS,MAX_POS])
//   pos       out  POS_W  current position (registered)
//   at_min    out  1      pos == MIN_POS (registered, consistent with pos)
//   at_max    out  1      pos == MAX_POS (registered, consistent with pos)
//   moved     out  1      1-cycle pulse: pos changed on this update
//   blocked   out  1      1-cycle pulse: tick with nonzero step clipped by a bound
// BEHAVIOUR
//   Reset (rst=1 at edge): pos=RST_POS, prescaler cnt=0, state=IDLE, moved=0, blocked=0,
//     at_min/at_max per RST_POS. Reset overrides load/en; mid-run reset discards pending tick.
//   FSM: IDLE --en=1--> RUN; RUN --en=0--> IDLE. Entering RUN clears cnt to 0.
//   RUN: cnt increments each cycle, wraps TICK_DIV-1 -> 0; tick = (state==RUN && cnt==TICK_DIV-1).
//     First tick occurs TICK_DIV cycles after the edge that enters RUN.
//   Tick update (registered, visible 1 cycle after tick edge):
//     sum = {2'b00,pos} + sign-extended step, computed in POS_W+2 bits signed;
//     sum < MIN_POS -> pos=MIN_POS; sum > MAX_POS -> pos=MAX_POS; else pos=sum.
//     moved = (new pos != old pos); blocked = (step!=0 && sum clipped).
//   step=0 on tick: pos unchanged, moved=0, blocked=0.
//   load=1 (and rst=0): pos=clamp(load_val), cnt=0, state unchanged; takes priority over tick
//     in the same cycle (tick's step discarded); moved=1 iff value changed, blocked=0.
//   en=0: pos, cnt hold; moved/blocked 0; load still honoured.
//   moved/blocked are 0 on every non-update cycle (never held high).
//   No wrap-around of pos ever; POS_W+2 intermediate prevents overflow for |step|<=128.
// TESTING
//   1 rst, then en=1, step=8'h01, TICK_DIV=4 -> pos 80,81,82 on cycles 4,8 after en; moved pulses.
//   2 load_val=158, step=8'h01 -> pos 159 then stays 159; at_max=1; blocked pulses, moved=0.
//   3 load_val=1, step=8'hFE (-2) -> pos 0 (clipped), at_min=1, moved=1, blocked=1; next tick blocked only.
//   4 load=1 on same cycle as tick with step=+1, load_val=10 -> pos=10, not 11; cnt restarts.
//   5 en toggled 1->0 mid-count (cnt=2), held 5 cycles, re-enabled -> first tick 4 cycles later.
//   6 rst asserted during RUN with pos=120 -> next cycle pos=80, moved=0, state IDLE; load_val=200 -> 159.

Source files
------------

// File: rtl/position_stepper.sv
// Bounded position register driven by signed steps at a prescaled tick rate.
// Saturates at MIN_POS/MAX_POS and reports edge, move and clip status.
module position_stepper #(
    parameter int POS_W    = 8,
    parameter int MIN_POS  = 0,
    parameter int MAX_POS  = 159,
    parameter int RST_POS  = 80,
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       step,
    input  logic             load,
    input  logic [POS_W-1:0] load_val,
    output logic [POS_W-1:0] pos,
    output logic             at_min,
    output logic             at_max,
    output logic             moved,
    output logic             blocked
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Signed intermediate wide enough for pos plus any 8-bit step.
    localparam int SUM_W = (POS_W + 2 > 9) ? POS_W + 2 : 9;

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic signed [SUM_W-1:0] MIN_S    = SUM_W'(MIN_POS);
    localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(MAX_POS);
    localparam logic [POS_W-1:0]        MIN_P    = POS_W'(MIN_POS);
    localparam logic [POS_W-1:0]        MAX_P    = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0]        RST_P    = POS_W'(RST_POS);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [POS_W-1:0]        pos_nx;
    logic                    moved_nx, blocked_nx;
    logic                    tick;
    logic signed [SUM_W-1:0] step_ext;
    logic signed [SUM_W-1:0] sum_tick;
    logic signed [SUM_W-1:0] sum_load;
    logic                    clipped;

    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [SUM_W-1:0] v);
        if (v < MIN_S) begin
            return MIN_P;
        end else if (v > MAX_S) begin
            return MAX_P;
        end else begin
            return v[POS_W-1:0];
        end
    endfunction

    always_comb begin
        step_ext = {{(SUM_W-8){step[7]}}, step};
        sum_tick = $signed({{(SUM_W-POS_W){1'b0}}, pos}) + step_ext;
        sum_load = $signed({{(SUM_W-POS_W){1'b0}}, load_val});
        clipped  = (sum_tick < MIN_S) || (sum_tick > MAX_S);
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pos_nx     = pos;
        moved_nx   = 1'b0;
        blocked_nx = 1'b0;
        tick       = (state == RUN) && en && (cnt == CNT_LAST);

        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        // Load wins over a coincident tick; that tick's step is dropped.
        if (load) begin
            cnt_nx   = '0;
            pos_nx   = clamp_pos(sum_load);
            moved_nx = (pos_nx != pos);
        end else if (tick) begin
            pos_nx     = clamp_pos(sum_tick);
            moved_nx   = (pos_nx != pos);
            blocked_nx = (step != 8'h00) && clipped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pos     <= RST_P;
            at_min  <= (RST_P == MIN_P);
            at_max  <= (RST_P == MAX_P);
            moved   <= 1'b0;
            blocked <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pos     <= pos_nx;
            at_min  <= (pos_nx == MIN_P);
            at_max  <= (pos_nx == MAX_P);
            moved   <= moved_nx;
            blocked <= blocked_nx;
        end
    end

endmodule

// File: tb/tb_position_stepper.sv
// Directed bench for position_stepper: a tick-countdown model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_position_stepper;

    localparam int POS_W    = 8;
    localparam int MIN_POS  = 0;
    localparam int MAX_POS  = 159;
    localparam int RST_POS  = 80;
    localparam int TICK_DIV = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [7:0]       step;
    logic             load;
    logic [POS_W-1:0] load_val;
    logic [POS_W-1:0] pos;
    logic             at_min, at_max, moved, blocked;

    int checks   = 0;
    int failures = 0;

    // Model: position, running flag, edges remaining until next tick.
    int m_pos;
    int m_rem;
    bit m_run;
    bit m_moved;
    bit m_blocked;
    bit m_valid = 1'b0;

    position_stepper #(
        .POS_W   (POS_W),
        .MIN_POS (MIN_POS),
        .MAX_POS (MAX_POS),
        .RST_POS (RST_POS),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .step    (step),
        .load    (load),
        .load_val(load_val),
        .pos     (pos),
        .at_min  (at_min),
        .at_max  (at_max),
        .moved   (moved),
        .blocked (blocked)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v);
        if (v < MIN_POS) return MIN_POS;
        if (v > MAX_POS) return MAX_POS;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit do_tick;
        int s;
        int nv;
        if (rst) begin
            m_pos     = RST_POS;
            m_run     = 1'b0;
            m_rem     = TICK_DIV;
            m_moved   = 1'b0;
            m_blocked = 1'b0;
            m_valid   = 1'b1;
        end else begin
            m_moved   = 1'b0;
            m_blocked = 1'b0;
            do_tick   = 1'b0;
            if (m_run && en) begin
                if (m_rem == 1) begin
                    do_tick = 1'b1;
                    m_rem   = TICK_DIV;
                end else begin
                    m_rem--;
                end
            end else if (!m_run && en) begin
                m_rem = TICK_DIV;
            end
            m_run = en;
            if (load) begin
                nv      = clampi(int'(load_val));
                m_moved = (nv != m_pos);
                m_pos   = nv;
                m_rem   = TICK_DIV;
            end else if (do_tick) begin
                s         = m_pos + int'($signed(step));
                nv        = clampi(s);
                m_moved   = (nv != m_pos);
                m_blocked = (step != 8'h00) && (nv != s);
                m_pos     = nv;
            end
        end
    endtask

    task automatic compare();
        chk("model_pos", int'(pos), m_pos);
        chk("model_at_min", int'(at_min), int'(m_pos == MIN_POS));
        chk("model_at_max", int'(at_max), int'(m_pos == MAX_POS));
        chk("model_moved", int'(moved), int'(m_moved));
        chk("model_blocked", int'(blocked), int'(m_blocked));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (m_valid) compare();
        end
    endtask

    logic [7:0] step_tab [5] = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h01};

    initial begin
        rst = 1'b1; en = 1'b0; step = 8'h00; load = 1'b0; load_val = '0;
        cyc(2);
        chk("rst_pos", int'(pos), 80);
        chk("rst_at_min", int'(at_min), 0);
        chk("rst_at_max", int'(at_max), 0);
        chk("rst_moved", int'(moved), 0);

        // Run at +1 per tick: ticks land 4 and 8 edges after entering RUN.
        rst = 1'b0; en = 1'b1; step = 8'h01;
        cyc(4);
        chk("t1_pre_tick", int'(pos), 80);
        cyc(1);
        chk("t1_pos81", int'(pos), 81);
        chk("t1_moved", int'(moved), 1);
        cyc(1);
        chk("t1_moved_drop", int'(moved), 0);
        cyc(3);
        chk("t1_pos82", int'(pos), 82);

        // Approach the upper bound.
        load = 1'b1; load_val = 8'd158;
        cyc(1);
        load = 1'b0;
        chk("t2_load158", int'(pos), 158);
        cyc(4);
        chk("t2_pos159", int'(pos), 159);
        chk("t2_at_max", int'(at_max), 1);
        cyc(4);
        chk("t2_blocked", int'(blocked), 1);
        chk("t2_no_move", int'(moved), 0);

        // -2 from 1 clips to 0.
        load = 1'b1; load_val = 8'd1; step = 8'hFE;
        cyc(1);
        load = 1'b0;
        cyc(4);
        chk("t3_pos0", int'(pos), 0);
        chk("t3_at_min", int'(at_min), 1);
        chk("t3_moved", int'(moved), 1);
        chk("t3_blocked", int'(blocked), 1);
        cyc(4);
        chk("t3_blocked_only", int'(blocked), 1);
        chk("t3_no_move", int'(moved), 0);

        // Load coinciding with a tick edge.
        cyc(3);
        load = 1'b1; load_val = 8'd10; step = 8'h01;
        cyc(1);
        load = 1'b0;
        chk("t4_load_wins", int'(pos), 10);
        chk("t4_not_blocked", int'(blocked), 0);
        cyc(3);
        chk("t4_restart_hold", int'(pos), 10);
        cyc(1);
        chk("t4_restart_tick", int'(pos), 11);

        // Pause at cnt=2, resume: full TICK_DIV wait.
        cyc(2);
        en = 1'b0;
        cyc(5);
        chk("t5_frozen", int'(pos), 11);
        en = 1'b1;
        cyc(4);
        chk("t5_no_early_tick", int'(pos), 11);
        cyc(1);
        chk("t5_tick", int'(pos), 12);

        // Reset mid-run, then an out-of-range load.
        load = 1'b1; load_val = 8'd120;
        cyc(1);
        load = 1'b0;
        chk("t6_pos120", int'(pos), 120);
        cyc(1);
        rst = 1'b1; load = 1'b1; load_val = 8'd200;
        cyc(1);
        chk("t6_rst_pos", int'(pos), 80);
        chk("t6_rst_moved", int'(moved), 0);
        rst = 1'b0;
        cyc(1);
        chk("t6_load_clamp", int'(pos), 159);
        chk("t6_load_at_max", int'(at_max), 1);
        load = 1'b0; step = 8'hFF;
        cyc(3);
        chk("t6_hold", int'(pos), 159);
        cyc(1);
        chk("t6_tick_down", int'(pos), 158);

        // Step table: 0, +127, -128, -1, +1 from 158.
        foreach (step_tab[i]) begin
            step = step_tab[i];
            cyc(4);
        end
        chk("tab_final", int'(pos), 31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
